keypad_mmio: RTL and testbench

CPU-side I/O port for the 4x4 keypad on the Minisys-1A bus. It samples the scanner's `key_code`/`key_pressed` pair and turns press events, plus optional auto-repeat, into codes queued in a small FIFO. The CPU reads queued codes at 0xFC10 and polls status at 0xFC12. The block sits between the keypad scanner and the CPU I/O address decoder.

---
 rtl/minisys_io_pkg.sv | 12 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/keypad_mmio.sv | 164 ++++++++++++++++
 tb/tb_keypad_mmio.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_io_pkg.sv
// rtl/minisys_io_pkg.sv - Minisys-1A I/O register addresses and keypad status bit layout
package minisys_io_pkg;

    localparam logic [15:0] KEY_DATA_ADDR = 16'hFC10;
    localparam logic [15:0] KEY_STAT_ADDR = 16'hFC12;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_COUNT_LO  = 2;
    localparam int STAT_COUNT_HI  = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; a push onto a full FIFO is accepted when a pop happens in the same cycle
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush behaves like reset, so a same-cycle push is discarded.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_mmio.sv
// rtl/keypad_mmio.sv - keypad press/auto-repeat event queue exposed as KEY_DATA/KEY_STAT I/O registers
module keypad_mmio
    import minisys_io_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter int          REPEAT_DELAY  = 50_000_000,
    parameter int          REPEAT_PERIOD = 10_000_000,
    parameter logic [15:0] ADDR_DATA     = KEY_DATA_ADDR,
    parameter logic [15:0] ADDR_STAT     = KEY_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_pressed,
    input  logic [15:0] io_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic        key_irq
);

    localparam int          CW          = $clog2(DEPTH + 1);
    localparam bit          REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic [31:0] DELAY_LAST  = REPEAT_EN ? 32'(REPEAT_DELAY - 1) : 32'd0;
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rep_state_t;

    rep_state_t     state, state_next;
    logic [31:0]    rcnt, rcnt_next;
    logic           kp_q, kp_d;
    logic [3:0]     kc_q, kc_d;
    logic           push, new_press, code_change;
    logic           rd_data_sel, rd_stat_sel, wr_stat;
    logic           flush, ovf_clr, ovf_set, overflow;
    logic           full, empty;
    logic [CW-1:0]  count;
    logic [2:0]     count3;
    logic [3:0]     head;
    logic [15:0]    stat_word;
    logic           unused_wdata;

    assign code_change = (kc_q != kc_d);
    assign new_press   = kp_q && (!kp_d || code_change);

    always_ff @(posedge clk) begin
        if (rst) begin
            kp_q  <= 1'b0;
            kp_d  <= 1'b0;
            kc_q  <= 4'h0;
            kc_d  <= 4'h0;
            state <= S_IDLE;
            rcnt  <= '0;
        end else begin
            kp_q  <= key_pressed;
            kp_d  <= kp_q;
            kc_q  <= key_code;
            kc_d  <= kc_q;
            state <= state_next;
            rcnt  <= rcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_press) begin
                    push       = 1'b1;
                    rcnt_next  = '0;
                    state_next = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!kp_q) begin
                    rcnt_next  = '0;
                    state_next = S_IDLE;
                end else if (code_change) begin
                    push       = 1'b1;
                    rcnt_next  = '0;
                    state_next = S_DELAY;
                end else if (state == S_DELAY) begin
                    // With auto-repeat disabled the block parks here until release.
                    if (REPEAT_EN && rcnt == DELAY_LAST) begin
                        push       = 1'b1;
                        rcnt_next  = '0;
                        state_next = S_REPEAT;
                    end else if (REPEAT_EN) begin
                        rcnt_next = rcnt + 32'd1;
                    end
                end else if (rcnt == PERIOD_LAST) begin
                    push      = 1'b1;
                    rcnt_next = '0;
                end else begin
                    rcnt_next = rcnt + 32'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

    assign rd_data_sel = io_rd && (io_addr == ADDR_DATA);
    assign rd_stat_sel = io_rd && (io_addr == ADDR_STAT);
    assign wr_stat     = io_wr && (io_addr == ADDR_STAT);
    assign flush       = wr_stat && io_wdata[0];
    assign ovf_clr     = wr_stat && io_wdata[1];
    assign ovf_set     = push && full && !rd_data_sel && !flush;
    assign unused_wdata = ^io_wdata[15:2];

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_data_sel),
        .flush (flush),
        .din   (kc_q),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            key_irq  <= 1'b0;
        end else begin
            key_irq <= !empty;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign count3 = 3'(count);

    always_comb begin
        stat_word                               = '0;
        stat_word[STAT_NOT_EMPTY]               = !empty;
        stat_word[STAT_OVERFLOW]                = overflow;
        stat_word[STAT_COUNT_HI:STAT_COUNT_LO]  = count3;
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (rd_data_sel) begin
            io_rdata = empty ? 16'h0000 : {12'h000, head};
        end else if (rd_stat_sel) begin
            io_rdata = stat_word;
        end
    end

endmodule

// File: tb/tb_keypad_mmio.sv
// tb/tb_keypad_mmio.sv - directed scoreboard bench for keypad_mmio with short repeat timing
module tb_keypad_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [15:0] io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        key_irq;

    int errors = 0;
    int checks = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    keypad_mmio #(
        .DEPTH         (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .ADDR_DATA     (16'hFC10),
        .ADDR_STAT     (16'hFC12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .io_addr     (io_addr),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .key_irq     (key_irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic read_stat(input string tag, input logic [15:0] exp);
        io_addr = 16'hFC12;
        io_rd   = 1'b1;
        #1;
        check(tag, io_rdata, exp);
        @(posedge clk);
        #1;
        io_rd   = 1'b0;
        io_addr = 16'h0000;
    endtask

    task automatic read_data(input string tag);
        logic [15:0] exp;
        exp = 16'h0000;
        if (sb.size() > 0) exp = {12'h000, sb.pop_front()};
        io_addr = 16'hFC10;
        io_rd   = 1'b1;
        #1;
        check(tag, io_rdata, exp);
        @(posedge clk);
        #1;
        io_rd   = 1'b0;
        io_addr = 16'h0000;
    endtask

    task automatic write_stat(input logic [15:0] data);
        io_addr  = 16'hFC12;
        io_wdata = data;
        io_wr    = 1'b1;
        @(posedge clk);
        #1;
        io_wr    = 1'b0;
        io_wdata = 16'h0000;
        io_addr  = 16'h0000;
    endtask

    task automatic press(input logic [3:0] code);
        key_code    = code;
        key_pressed = 1'b1;
        tick(2);
        key_pressed = 1'b0;
        tick(2);
    endtask

    initial begin
        rst         = 1'b1;
        key_code    = 4'h0;
        key_pressed = 1'b0;
        io_addr     = 16'h0000;
        io_rd       = 1'b0;
        io_wr       = 1'b0;
        io_wdata    = 16'h0000;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("reset_irq", {15'h0, key_irq}, 16'h0000);
        check("reset_idle_rdata", io_rdata, 16'h0000);
        read_stat("reset_stat", 16'h0000);

        // Single short press of 7
        key_code    = 4'h7;
        key_pressed = 1'b1;
        tick(3);
        key_pressed = 1'b0;
        sb.push_back(4'h7);
        tick(3);
        check("press7_irq", {15'h0, key_irq}, 16'h0001);
        read_stat("press7_stat", 16'h0005);
        read_data("press7_data");
        read_stat("press7_stat_empty", 16'h0000);
        check("press7_irq_clear", {15'h0, key_irq}, 16'h0000);

        // Hold A for 31 cycles after the initial push: pushes at 0, +20, +25, +30
        key_code    = 4'hA;
        key_pressed = 1'b1;
        tick(2);
        tick(31);
        key_pressed = 1'b0;
        repeat (4) sb.push_back(4'hA);
        tick(4);
        read_stat("hold_a_stat", 16'h0011);
        repeat (4) read_data("hold_a_data");
        read_stat("hold_a_empty", 16'h0000);

        // Five presses into a 4-deep queue
        for (int c = 1; c <= 5; c++) press(4'(c));
        for (int c = 1; c <= 4; c++) sb.push_back(4'(c));
        tick(2);
        read_stat("ovf_stat", 16'h0013);
        repeat (4) read_data("ovf_data");
        read_stat("ovf_still_set", 16'h0002);
        write_stat(16'h0002);
        read_stat("ovf_cleared", 16'h0000);

        // Full queue, fifth push lands on the same edge as a KEY_DATA pop
        for (int c = 11; c <= 14; c++) begin
            press(4'(c));
            sb.push_back(4'(c));
        end
        tick(2);
        key_code    = 4'hF;
        key_pressed = 1'b1;
        tick(1);
        read_data("full_pop_push_data");
        sb.push_back(4'hF);
        key_pressed = 1'b0;
        tick(3);
        read_stat("full_pop_push_stat", 16'h0011);
        repeat (4) read_data("full_pop_push_drain");
        read_stat("full_pop_push_empty", 16'h0000);

        // Code change 3 -> 9 while held restarts the repeat delay
        key_code    = 4'h3;
        key_pressed = 1'b1;
        tick(2);
        sb.push_back(4'h3);
        tick(5);
        key_code = 4'h9;
        tick(2);
        sb.push_back(4'h9);
        tick(19);
        read_stat("change_before_repeat", 16'h0009);
        sb.push_back(4'h9);
        read_stat("change_first_repeat", 16'h000D);
        key_pressed = 1'b0;
        tick(4);
        repeat (3) read_data("change_data");
        read_stat("change_empty", 16'h0000);

        // Flush with three entries queued
        for (int c = 2; c <= 6; c += 2) begin
            press(4'(c));
            sb.push_back(4'(c));
        end
        tick(2);
        read_stat("flush_before", 16'h000D);
        write_stat(16'h0001);
        sb.delete();
        read_stat("flush_after", 16'h0000);
        read_data("flush_data_empty");

        // Reset in the middle of the repeat delay while 6 is held
        key_code    = 4'h6;
        key_pressed = 1'b1;
        tick(2);
        sb.push_back(4'h6);
        tick(5);
        rst = 1'b1;
        tick(2);
        sb.delete();
        check("rst_mid_irq", {15'h0, key_irq}, 16'h0000);
        read_stat("rst_mid_stat", 16'h0000);
        rst = 1'b0;
        sb.push_back(4'h6);
        tick(3);
        check("rst_repush_irq", {15'h0, key_irq}, 16'h0001);
        key_pressed = 1'b0;
        tick(3);
        read_stat("rst_repush_stat", 16'h0005);
        read_data("rst_repush_data");
        read_stat("rst_repush_empty", 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
